// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 receiver.
// Holds the deframer state enum, frame geometry, scan codes and the key lookup.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // Player 1 keys are plain codes, player 2 keys follow an E0 prefix
  localparam logic [7:0] SC_P1_UP    = 8'h1D;
  localparam logic [7:0] SC_P1_DOWN  = 8'h1B;
  localparam logic [7:0] SC_P1_LEFT  = 8'h1C;
  localparam logic [7:0] SC_P1_RIGHT = 8'h23;
  localparam logic [7:0] SC_P2_UP    = 8'h75;
  localparam logic [7:0] SC_P2_DOWN  = 8'h72;
  localparam logic [7:0] SC_P2_LEFT  = 8'h6B;
  localparam logic [7:0] SC_P2_RIGHT = 8'h74;

  // Bit positions of each held key inside the key level vector
  localparam int KEY_P1_UP    = 0;
  localparam int KEY_P1_DOWN  = 1;
  localparam int KEY_P1_LEFT  = 2;
  localparam int KEY_P1_RIGHT = 3;
  localparam int KEY_P2_UP    = 4;
  localparam int KEY_P2_DOWN  = 5;
  localparam int KEY_P2_LEFT  = 6;
  localparam int KEY_P2_RIGHT = 7;

  // Maps (ext, code) to {hit, key index}; hit=0 for unmapped codes
  function automatic logic [3:0] key_lookup(input logic ext, input logic [7:0] code);
    logic [3:0] res;
    res = 4'b0000;
    if (!ext) begin
      case (code)
        SC_P1_UP:    res = {1'b1, 3'(KEY_P1_UP)};
        SC_P1_DOWN:  res = {1'b1, 3'(KEY_P1_DOWN)};
        SC_P1_LEFT:  res = {1'b1, 3'(KEY_P1_LEFT)};
        SC_P1_RIGHT: res = {1'b1, 3'(KEY_P1_RIGHT)};
        default:     res = 4'b0000;
      endcase
    end else begin
      case (code)
        SC_P2_UP:    res = {1'b1, 3'(KEY_P2_UP)};
        SC_P2_DOWN:  res = {1'b1, 3'(KEY_P2_DOWN)};
        SC_P2_LEFT:  res = {1'b1, 3'(KEY_P2_LEFT)};
        SC_P2_RIGHT: res = {1'b1, 3'(KEY_P2_RIGHT)};
        default:     res = 4'b0000;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: two-flop synchronizers on the PS/2 pins, a glitch filter on
// the clock line and a falling-edge detector on the filtered clock.
// fall pulses for one cycle; data_s is the synchronized data line.
module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_s
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       clk_sync_q;
  logic [1:0]       data_sync_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fall_q, fall_d;

  // Synchronizers; idle bus level is high so they reset to 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  // Filter: flip only after FILTER_LEN consecutive samples disagree; any agreeing sample restarts the count
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    fall_d = 1'b0;
    if (clk_sync_q[1] != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = clk_sync_q[1];
        fall_d = filt_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filter state and edge pulse register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
      fall_q <= 1'b0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      fall_q <= fall_d;
    end
  end

  assign fall   = fall_q;
  assign data_s = data_sync_q[1];

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver. Deframes 11-bit frames into bytes with
// valid/error strobes and a watchdog for stalled frames.
// Define PS2_KEYMAP_EN to compile in the make/break decoder for the eight
// paddle keys; without it the key outputs are tied to 0.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p1_left,
  output logic       p1_right,
  output logic       p2_up,
  output logic       p2_down,
  output logic       p2_left,
  output logic       p2_right
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  logic fall;
  logic data_s;

  ps2_state_e      state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_err_q, rx_err_d;
  logic [7:0]      key_lvl;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall     (fall),
    .data_s   (data_s)
  );

  // Deframer next state, shift register, result strobes and watchdog
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    wd_d       = wd_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        wd_d      = '0;
        // A falling edge with data high is not a start bit and is dropped
        if (fall && !data_s) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d = {data_s, shift_q[7:1]};
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          parity_d = data_s;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          if (data_s && (^{shift_q, parity_q})) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Watchdog: an edge restarts it; running out abandons the frame
    if (state_q != IDLE) begin
      if (fall) begin
        wd_d = '0;
      end else if (wd_q == WD_LAST) begin
        wd_d       = '0;
        bit_cnt_d  = '0;
        state_d    = IDLE;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  // Deframer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      wd_q       <= '0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      wd_q       <= wd_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end

`ifdef PS2_KEYMAP_EN
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [7:0] keys_q, keys_d;
  logic [3:0] hit;

  // Scan-code decoder: prefixes arm ext/brk, any other byte consumes them
  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    keys_d = keys_q;
    hit    = key_lookup(ext_q, rx_data_q);
    if (rx_err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid_q) begin
      if (rx_data_q == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_data_q == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        if (hit[3]) begin
          keys_d[hit[2:0]] = !brk_q;
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  // Decoder registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      keys_q <= '0;
    end else begin
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      keys_q <= keys_d;
    end
  end

  assign key_lvl = keys_q;
`else
  assign key_lvl = '0;
`endif

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;

  assign p1_up    = key_lvl[KEY_P1_UP];
  assign p1_down  = key_lvl[KEY_P1_DOWN];
  assign p1_left  = key_lvl[KEY_P1_LEFT];
  assign p1_right = key_lvl[KEY_P1_RIGHT];
  assign p2_up    = key_lvl[KEY_P2_UP];
  assign p2_down  = key_lvl[KEY_P2_DOWN];
  assign p2_left  = key_lvl[KEY_P2_LEFT];
  assign p2_right = key_lvl[KEY_P2_RIGHT];

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed plus randomized frames against a byte/key reference model.
// Timing is scaled down (short PS/2 bit period, short watchdog) to keep runs short.
module tb_ps2_rx;

  localparam int FL   = 8;
  localparam int TO   = 1000;
  localparam int HALF = 60;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_err;
  logic       p1_up, p1_down, p1_left, p1_right;
  logic       p2_up, p2_down, p2_left, p2_right;
  logic [7:0] keys;

  assign keys = {p2_right, p2_left, p2_down, p2_up, p1_right, p1_left, p1_down, p1_up};

  always #5 clk = ~clk;

  ps2_rx #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .p1_up    (p1_up),
    .p1_down  (p1_down),
    .p1_left  (p1_left),
    .p1_right (p1_right),
    .p2_up    (p2_up),
    .p2_down  (p2_down),
    .p2_left  (p2_left),
    .p2_right (p2_right)
  );

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;
  logic [7:0] last_byte = 8'h00;

  // reference model state
  logic [7:0] m_data = 8'h00;
  logic [7:0] m_keys = 8'h00;
  bit         m_ext = 1'b0;
  bit         m_brk = 1'b0;

  // strobe monitor: counts every strobe cycle, flags overlap
  always @(negedge clk) begin
    if (reset) begin
      if (rx_valid) begin
        n_valid++;
        last_byte = rx_data;
      end
      if (rx_err) n_err++;
      if (rx_valid || rx_err) begin
        checks++;
        assert (!(rx_valid && rx_err)) else begin
          errors++;
          $error("FAIL strobe_overlap observed valid=%0b err=%0b expected not both high", rx_valid, rx_err);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] exp_keys();
`ifdef PS2_KEYMAP_EN
    return m_keys;
`else
    return 8'h00;
`endif
  endfunction

  // make/break model: order {p2_right,p2_left,p2_down,p2_up,p1_right,p1_left,p1_down,p1_up}
  task automatic model_byte(input logic [7:0] d);
    m_data = d;
    if (d == 8'hE0) m_ext = 1'b1;
    else if (d == 8'hF0) m_brk = 1'b1;
    else begin
      case ({m_ext, d})
        9'h01D: m_keys[0] = !m_brk;
        9'h01B: m_keys[1] = !m_brk;
        9'h01C: m_keys[2] = !m_brk;
        9'h023: m_keys[3] = !m_brk;
        9'h175: m_keys[4] = !m_brk;
        9'h172: m_keys[5] = !m_brk;
        9'h16B: m_keys[6] = !m_brk;
        9'h174: m_keys[7] = !m_brk;
        default: ;
      endcase
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_data = 8'h00;
    m_keys = 8'h00;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
  endtask

  // {stop, parity, data, start}; parity makes the 9-bit count odd unless flipped
  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit flip);
    logic p;
    p = (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;
    if (flip) p = !p;
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (glitch) begin
        wait_cyc(10);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(HALF / 2 - 13);
      end else begin
        wait_cyc(HALF / 2);
      end
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
      wait_cyc(HALF / 2);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_and_check(input string tag, input logic [7:0] d, input bit flip, input bit glitch);
    int v0, e0;
    logic [10:0] fr;
    bit good;
    v0 = n_valid;
    e0 = n_err;
    fr = mk_frame(d, flip);
    send_bits(fr, 11, glitch);
    wait_cyc(40);
    good = ($countones(fr[9:1]) % 2) == 1;
    if (good) model_byte(d);
    else begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    $display("frame %s byte=%02h flip=%0b glitch=%0b -> valid=%0d err=%0d rx_data=%02h keys=%02h",
             tag, d, flip, glitch, n_valid - v0, n_err - e0, rx_data, keys);
    chk({tag, "_valid_cnt"}, 32'(n_valid - v0), good ? 32'd1 : 32'd0);
    chk({tag, "_err_cnt"}, 32'(n_err - e0), good ? 32'd0 : 32'd1);
    chk({tag, "_rx_data"}, {24'h0, rx_data}, {24'h0, m_data});
    chk({tag, "_keys"}, {24'h0, keys}, {24'h0, exp_keys()});
  endtask

  initial begin
    int v0, e0;
    logic [7:0] pool [12];
    logic [7:0] d;
    bit flip;
    pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74,
             8'hE0, 8'hF0, 8'hE0, 8'hF0};

    // reset state
    wait_cyc(10);
    chk("reset_rx_data", {24'h0, rx_data}, 32'h0);
    chk("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    chk("reset_rx_err", {31'h0, rx_err}, 32'h0);
    chk("reset_keys", {24'h0, keys}, 32'h0);
    reset = 1'b1;
    wait_cyc(20);

    // bad parity before any good frame: error, rx_data stays 00
    send_and_check("bad_parity_1c", 8'h1C, 1'b1, 1'b0);
    send_and_check("good_1c", 8'h1C, 1'b0, 1'b0);

    // watchdog: start + 5 data bits then silence
    v0 = n_valid;
    e0 = n_err;
    send_bits(mk_frame(8'h23, 1'b0), 6, 1'b0);
    wait_cyc(TO - 200);
    chk("timeout_not_early", 32'(n_err - e0), 32'd0);
    wait_cyc(500);
    $display("frame timeout partial -> valid=%0d err=%0d", n_valid - v0, n_err - e0);
    chk("timeout_err_cnt", 32'(n_err - e0), 32'd1);
    chk("timeout_valid_cnt", 32'(n_valid - v0), 32'd0);
    m_ext = 1'b0;
    m_brk = 1'b0;
    send_and_check("after_timeout_23", 8'h23, 1'b0, 1'b0);

    // glitches on ps2_clk shorter than the filter
    send_and_check("glitch_75", 8'h75, 1'b0, 1'b1);

    // make and break sequences
    send_and_check("key_1d", 8'h1D, 1'b0, 1'b0);
    send_and_check("key_e0", 8'hE0, 1'b0, 1'b0);
    send_and_check("key_75", 8'h75, 1'b0, 1'b0);
    send_and_check("key_f0", 8'hF0, 1'b0, 1'b0);
    send_and_check("key_brk_1d", 8'h1D, 1'b0, 1'b0);
`ifdef PS2_KEYMAP_EN
    chk("p1_up_released", {31'h0, p1_up}, 32'd0);
    chk("p2_up_held", {31'h0, p2_up}, 32'd1);
`endif

    // reset in the middle of a frame
    v0 = n_valid;
    e0 = n_err;
    send_bits(mk_frame(8'h5A, 1'b0), 4, 1'b0);
    reset = 1'b0;
    model_reset();
    wait_cyc(5);
    chk("midreset_valid", {31'h0, rx_valid}, 32'd0);
    chk("midreset_err", {31'h0, rx_err}, 32'd0);
    chk("midreset_data", {24'h0, rx_data}, 32'h0);
    wait_cyc(15);
    reset = 1'b1;
    wait_cyc(40);
    chk("midreset_no_strobe", 32'((n_valid - v0) + (n_err - e0)), 32'd0);
    send_and_check("after_reset_aa", 8'hAA, 1'b0, 1'b0);

    // randomized frames, biased toward key-related codes
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 1) == 0) d = 8'($urandom_range(0, 255));
      else d = pool[$urandom_range(0, 11)];
      flip = ($urandom_range(0, 3) == 0);
      send_and_check("rand", d, flip, bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
# ps2_rx

PS/2 host-side receiver for the keyboard attached to the VGA top level's `ps2_clk`/`ps2_data` pins. Samples the device-driven PS/2 clock and data lines in the 100 MHz system domain and deframes 11-bit device-to-host frames into bytes with a one-cycle valid strobe. Flags framing errors. Optionally decodes make/break scan codes into the eight held-key levels that drive paddle movement (`p1_up` … `p2_right`).

## Interface
- `FILTER_LEN`, default 8: number of consecutive identical `clk` samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, default 200000: maximum `clk` cycles between PS/2 falling edges inside a frame (2 ms at 100 MHz).
- `clk` in 1: 100 MHz system clock.
- `reset` in 1: reset, asynchronous, active-low.
- `ps2_clk` in 1: PS/2 clock line, asynchronous; never driven by this block.
- `ps2_data` in 1: PS/2 data line, asynchronous; never driven by this block.
- `rx_data` out 8: last received byte; holds until the next good frame.
- `rx_valid` out 1: one-cycle strobe; `rx_data` is new.
- `rx_err` out 1: one-cycle strobe on parity, stop or timeout error.
- `p1_up`, `p1_down`, `p1_left`, `p1_right`, `p2_up`, `p2_down`, `p2_left`, `p2_right` out 1 each: held-key levels.

## Operation
- Synchronizer: two flops on each of `ps2_clk` and `ps2_data`.
- Filter: a counter on synchronized `ps2_clk`. Filtered level flips only after `FILTER_LEN` consecutive samples differ from it.
- Falling edge: filtered high→low. `ps2_data` is sampled (synchronized) on that cycle.
- State machine:
  - IDLE → DATA on an edge with data=0 (start bit). An edge with data=1 stays in IDLE and is ignored.
  - DATA: shift data in LSB first, `bit_cnt` 0..7. After the 8th bit → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: if stop=1 and the 9 bits (data plus parity) have odd parity, load `rx_data` and pulse `rx_valid`. Otherwise pulse `rx_err`. Either way → IDLE.
- Watchdog: a counter cleared on every edge and counting only outside IDLE. Reaching `TIMEOUT_CYCLES` pulses `rx_err`, clears `bit_cnt` and goes to IDLE. A later start bit begins a fresh frame.
- `rx_valid` and `rx_err` are never high together.
- Reset mid-frame: partial frame is discarded; no strobe.

## Timing
- Reset values:
  - All outputs are 0, including `rx_data` = 8'h00.
  - State is IDLE; filtered clock level is 1; counters are 0.
- Edge detection latency: 2 (sync) + `FILTER_LEN` cycles after the pin transition.
- `rx_valid`/`rx_err` assert on the cycle after the stop-bit edge is detected, and last exactly 1 cycle.
- Key outputs update on the cycle after `rx_valid`.
- Glitches shorter than `FILTER_LEN` cycles on `ps2_clk` produce no edge.

## Configuration
- `PS2_KEYMAP_EN` defined: the scan-code decoder is compiled in.
  - An `8'hE0` byte sets `ext`; an `8'hF0` byte sets `brk`.
  - Any other byte: if (`ext`, code) matches a key, set that key to `!brk`. Then clear `ext` and `brk`.
  - `rx_err` clears `ext` and `brk`; key levels are kept.
  - Player 1 map: W=1D up, S=1B down, A=1C left, D=23 right, all with `ext`=0.
  - Player 2 map: E0 75 up, E0 72 down, E0 6B left, E0 74 right.
  - Unmapped codes are ignored.
- `PS2_KEYMAP_EN` undefined: the decoder is absent and all eight key outputs are constant 0. `rx_data`, `rx_valid` and `rx_err` are unaffected.

## Structure
- Package `ps2_pkg`: state enum (IDLE, DATA, PARITY, STOP); frame constants (8 data bits, 11-bit frame); scan-code constants (E0, F0 and the eight key codes).
- Sub-module `ps2_clk_filter`: synchronizer plus glitch filter plus falling-edge detector. Outputs `fall` (1-cycle pulse) and `data_s` (synchronized data).
- Top `ps2_rx`: deframer FSM, watchdog and the optional keymap.

## Test plan
- Frame for 8'h1C at 10 kHz PS/2 clock (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1) → one `rx_valid`, `rx_data`=8'h1C, no `rx_err`.
- Same frame with parity flipped to 1 → one `rx_err`, no `rx_valid`, `rx_data` still 8'h00.
- Five data bits, then the line idles 250000 cycles, then a full frame 8'h23 → one `rx_err` at the timeout, then `rx_valid` with 8'h23.
- 3-cycle low pulses on `ps2_clk` between real edges of a 8'h75 frame → `rx_data`=8'h75, no error.
- `PS2_KEYMAP_EN`: bytes 1D, then E0 75 → `p1_up`=1 and `p2_up`=1. Then F0 1D → `p1_up`=0, `p2_up` still 1.
- Reset asserted after 4 bits, released, then a full 8'hAA frame → no strobe during reset; afterwards a single `rx_valid` with 8'hAA.
